tlb_op_ctrl: RTL

Sequences CP0 TLB instructions (TLBP, TLBR, TLBWI) onto the TLB's search port s1, read port and write port, and returns results to CP0. Sits between the CP0/exception stage and the TLB. Shares search port s1 between TLBP and the data-side address-translation requester, with a bounded-wait guard so TLBP is never starved.

---
 rtl/tlb_pkg.sv | 37 +++
 rtl/tlb_entry_pack.sv | 31 +++
 rtl/tlb_op_ctrl.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/tlb_pkg.sv
// Shared definitions for the CP0 TLB operation controller: op codes, packed
// TLB entry layout and controller state encoding.
package tlb_pkg;

    localparam logic [1:0] OP_TLBWR = 2'b00;
    localparam logic [1:0] OP_TLBP  = 2'b01;
    localparam logic [1:0] OP_TLBR  = 2'b10;
    localparam logic [1:0] OP_TLBWI = 2'b11;

    // Packed entry, MSB first: vpn2 | asid | g | pfn0 c0 d0 v0 | pfn1 c1 d1 v1
    localparam int ENTRY_W  = 78;
    localparam int VPN2_W   = 19;
    localparam int ASID_W   = 8;
    localparam int PFN_W    = 20;
    localparam int C_W      = 3;
    localparam int VPN2_LSB = 59;
    localparam int ASID_LSB = 51;
    localparam int G_BIT    = 50;
    localparam int PFN0_LSB = 30;
    localparam int C0_LSB   = 27;
    localparam int D0_BIT   = 26;
    localparam int V0_BIT   = 25;
    localparam int PFN1_LSB = 5;
    localparam int C1_LSB   = 2;
    localparam int D1_BIT   = 1;
    localparam int V1_BIT   = 0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_P_WAIT = 3'd1,
        ST_P_SRCH = 3'd2,
        ST_RD     = 3'd3,
        ST_WR     = 3'd4,
        ST_DONE   = 3'd5
    } tlb_state_e;

endpackage

// File: rtl/tlb_entry_pack.sv
// Combinational conversion between CP0 register format (EntryHi/EntryLo0/
// EntryLo1) and the packed TLB entry, in both directions.
module tlb_entry_pack
    import tlb_pkg::*;
(
    input  logic [31:0]        entryhi_i,
    input  logic [31:0]        entrylo0_i,
    input  logic [31:0]        entrylo1_i,
    output logic [ENTRY_W-1:0] packed_o,
    input  logic [ENTRY_W-1:0] packed_i,
    output logic [31:0]        entryhi_o,
    output logic [31:0]        entrylo0_o,
    output logic [31:0]        entrylo1_o
);

    // The entry has a single G bit: it is global only if both halves say so.
    assign packed_o = {entryhi_i[31:13], entryhi_i[7:0],
                       entrylo0_i[0] & entrylo1_i[0],
                       entrylo0_i[25:6], entrylo0_i[5:3], entrylo0_i[2], entrylo0_i[1],
                       entrylo1_i[25:6], entrylo1_i[5:3], entrylo1_i[2], entrylo1_i[1]};

    assign entryhi_o  = {packed_i[VPN2_LSB +: VPN2_W], 5'b0, packed_i[ASID_LSB +: ASID_W]};
    assign entrylo0_o = {6'b0, packed_i[PFN0_LSB +: PFN_W], packed_i[C0_LSB +: C_W],
                         packed_i[D0_BIT], packed_i[V0_BIT], packed_i[G_BIT]};
    assign entrylo1_o = {6'b0, packed_i[PFN1_LSB +: PFN_W], packed_i[C1_LSB +: C_W],
                         packed_i[D1_BIT], packed_i[V1_BIT], packed_i[G_BIT]};

    logic unused_bits;
    assign unused_bits = ^{entryhi_i[12:8], entrylo0_i[31:26], entrylo1_i[31:26]};

endmodule

// File: rtl/tlb_op_ctrl.sv
// Sequences TLBP/TLBR/TLBWI onto the TLB ports and arbitrates search port s1
// with the data side. Define TLB_RAND_EN to make op code 00 a TLBWR.
module tlb_op_ctrl
    import tlb_pkg::*;
#(
    parameter  int TLBNUM   = 16,
    parameter  int MAX_WAIT = 8,
    localparam int IDX_W    = $clog2(TLBNUM)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               op_valid,
    output logic               op_ready,
    input  logic [1:0]         op_code,
    input  logic [31:0]        cp0_index,
    input  logic [31:0]        cp0_entryhi,
    input  logic [31:0]        cp0_entrylo0,
    input  logic [31:0]        cp0_entrylo1,
    output logic               op_done,
    output logic               res_index_we,
    output logic [31:0]        res_index,
    output logic               res_entry_we,
    output logic [31:0]        res_entryhi,
    output logic [31:0]        res_entrylo0,
    output logic [31:0]        res_entrylo1,
    input  logic               ds_req,
    input  logic [18:0]        ds_vpn2,
    input  logic               ds_odd,
    input  logic [7:0]         ds_asid,
    output logic               ds_gnt,
    output logic [18:0]        s1_vpn2,
    output logic               s1_odd_page,
    output logic [7:0]         s1_asid,
    input  logic               s1_found,
    input  logic [IDX_W-1:0]   s1_index,
    output logic               we,
    output logic [IDX_W-1:0]   w_index,
    output logic [ENTRY_W-1:0] w_entry,
    output logic [IDX_W-1:0]   r_index,
    input  logic [ENTRY_W-1:0] r_entry,
    output tlb_state_e         dbg_state_o
);

    localparam int WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

    tlb_state_e        state_q, state_d;
    logic [1:0]        op_q;
    logic [IDX_W-1:0]  idx_q;
    logic [31:0]       hi_q, lo0_q, lo1_q;
    logic [WAIT_W-1:0] wait_cnt_q;
    logic              op_done_q, res_index_we_q, res_entry_we_q, we_q;
    logic [31:0]       res_index_q, res_hi_q, res_lo0_q, res_lo1_q;
    logic [31:0]       rd_hi, rd_lo0, rd_lo1;
    logic [IDX_W-1:0]  acc_idx;
    logic              accept;
    logic              in_srch;

    // Handshake: an operation is taken on a clock edge where op_valid && op_ready;
    // op_ready is high only in IDLE, and op_valid seen in any other state is ignored.
    assign op_ready = (state_q == ST_IDLE);
    assign accept   = op_valid && op_ready;
    assign in_srch  = (state_q == ST_P_SRCH);

`ifdef TLB_RAND_EN
    logic [IDX_W-1:0] rand_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rand_q <= IDX_W'(TLBNUM - 1);
        end else if (rand_q == '0) begin
            rand_q <= IDX_W'(TLBNUM - 1);
        end else begin
            rand_q <= rand_q - 1'b1;
        end
    end

    assign acc_idx = (op_code == OP_TLBWR) ? rand_q : cp0_index[IDX_W-1:0];
`else
    assign acc_idx = cp0_index[IDX_W-1:0];
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (op_valid) begin
                    unique case (op_code)
                        // With s1 free at accept, TLBP spends no cycles waiting.
                        OP_TLBP:  state_d = ds_req ? ST_P_WAIT : ST_P_SRCH;
                        OP_TLBR:  state_d = ST_RD;
                        OP_TLBWI: state_d = ST_WR;
`ifdef TLB_RAND_EN
                        default:  state_d = ST_WR;
`else
                        default:  state_d = ST_DONE;
`endif
                    endcase
                end
            end
            ST_P_WAIT: begin
                if (!ds_req || (wait_cnt_q == WAIT_W'(MAX_WAIT - 1))) begin
                    state_d = ST_P_SRCH;
                end
            end
            ST_P_SRCH, ST_RD, ST_WR: state_d = ST_DONE;
            ST_DONE:                 state_d = ST_IDLE;
            default:                 state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            op_q           <= '0;
            idx_q          <= '0;
            hi_q           <= '0;
            lo0_q          <= '0;
            lo1_q          <= '0;
            wait_cnt_q     <= '0;
            op_done_q      <= 1'b0;
            res_index_we_q <= 1'b0;
            res_entry_we_q <= 1'b0;
            we_q           <= 1'b0;
            res_index_q    <= '0;
            res_hi_q       <= '0;
            res_lo0_q      <= '0;
            res_lo1_q      <= '0;
        end else begin
            state_q        <= state_d;
            op_done_q      <= (state_d == ST_DONE);
            we_q           <= (state_d == ST_WR);
            res_index_we_q <= (state_q == ST_P_SRCH);
            res_entry_we_q <= (state_q == ST_RD);

            if (accept) begin
                op_q  <= op_code;
                idx_q <= acc_idx;
                hi_q  <= cp0_entryhi;
                lo0_q <= cp0_entrylo0;
                lo1_q <= cp0_entrylo1;
            end

            if (state_d == ST_P_SRCH) begin
                wait_cnt_q <= '0;
            end else if (state_q == ST_P_WAIT && ds_req) begin
                wait_cnt_q <= wait_cnt_q + 1'b1;
            end

            if (in_srch) begin
                res_index_q <= s1_found ? {{(32-IDX_W){1'b0}}, s1_index} : 32'h8000_0000;
            end

            if (state_q == ST_RD) begin
                res_hi_q  <= rd_hi;
                res_lo0_q <= rd_lo0;
                res_lo1_q <= rd_lo1;
            end
        end
    end

    tlb_entry_pack u_pack (
        .entryhi_i  (hi_q),
        .entrylo0_i (lo0_q),
        .entrylo1_i (lo1_q),
        .packed_o   (w_entry),
        .packed_i   (r_entry),
        .entryhi_o  (rd_hi),
        .entrylo0_o (rd_lo0),
        .entrylo1_o (rd_lo1)
    );

    // s1 belongs to the data side except for the single TLBP search cycle.
    assign ds_gnt       = ds_req && !in_srch;
    assign s1_vpn2      = in_srch ? hi_q[31:13] : ds_vpn2;
    assign s1_asid      = in_srch ? hi_q[7:0]   : ds_asid;
    assign s1_odd_page  = in_srch ? 1'b0        : ds_odd;

    assign we           = we_q;
    assign w_index      = idx_q;
    assign r_index      = idx_q;
    assign op_done      = op_done_q;
    assign res_index_we = res_index_we_q;
    assign res_index    = res_index_q;
    assign res_entry_we = res_entry_we_q;
    assign res_entryhi  = res_hi_q;
    assign res_entrylo0 = res_lo0_q;
    assign res_entrylo1 = res_lo1_q;
    assign dbg_state_o  = state_q;

    logic unused_bits;
    assign unused_bits = ^{op_q, cp0_index[31:IDX_W]};

endmodule
